// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request unit.
// Register addresses, source bit indices and vector helpers.
package irq_pkg;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [7:0] IRQ_VEC_BASE = 8'h40;

  function automatic logic [7:0] irq_vector(input int idx);
    irq_vector = IRQ_VEC_BASE + 8'(idx * 8);
  endfunction

endpackage

// File: rtl/irq_flag_bit.sv
// One IF bit: source edge detect plus set/ack/write priority.
// A fresh edge always wins over a clear in the same cycle.
module irq_flag_bit (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic wstb_i,
  input  logic wdata_i,
  input  logic ack_i,
  output logic flag_o
);

  logic src_q;
  logic flag_q;
  logic flag_d;
  logic set;
  logic base;

  always_comb begin
    set    = src_i & ~src_q;
    base   = wstb_i ? wdata_i : flag_q;
    base   = base & ~ack_i;
    flag_d = base | set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      src_q  <= src_i;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/irq_request_unit.sv
// IF register (0xFF0F): edge-captured peripheral requests,
// core trigger/acknowledge and CPU bus access.
module irq_request_unit
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 5,
  parameter logic [15:0] IF_ADDR     = irq_pkg::IF_ADDR,
  parameter logic        UNUSED_READ = 1'b1
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic [NUM_IRQ-1:0] IRQ_SRC,
  input  logic [15:0]        A,
  input  logic [7:0]         D_IN,
  input  logic               RD,
  input  logic               WR,
  output logic [7:0]         D_OUT,
  output logic               D_OE,
  output logic [7:0]         CPU_IRQ_TRIG,
  input  logic [7:0]         CPU_IRQ_ACK
);

  logic               sel;
  logic               wr_q;
  logic               wstb;
  logic [NUM_IRQ-1:0] if_vec;
  logic               unused_hi;

  assign sel  = (A == IF_ADDR);
  // Only the first cycle of a WR pulse commits.
  assign wstb = WR & ~wr_q & sel;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= WR;
    end
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_bit
    irq_flag_bit u_bit (
      .clk_i   (CLK),
      .rst_ni  (nRESET),
      .src_i   (IRQ_SRC[i]),
      .wstb_i  (wstb),
      .wdata_i (D_IN[i]),
      .ack_i   (CPU_IRQ_ACK[i]),
      .flag_o  (if_vec[i])
    );
  end

  assign D_OE  = RD & sel & nRESET;
  assign D_OUT = D_OE ? {{(8-NUM_IRQ){UNUSED_READ}}, if_vec}
                      : 8'h00;

  assign CPU_IRQ_TRIG = {{(8-NUM_IRQ){1'b0}}, if_vec};

  assign unused_hi = ^{D_IN[7:NUM_IRQ], CPU_IRQ_ACK[7:NUM_IRQ]};

endmodule
